// File: rtl/buffer_mac_pkg.sv
// buffer_mac_pkg: shared definitions for buffer_mac_array.
//   - Default values for the array parameters.
//   - FSM state enum.
//   - quantise(): arithmetic right shift followed by reduction to data_w bits.
// Build option: define BUFFER_MAC_SAT_EN to make the reduction saturate;
// otherwise it wraps (keeps the low data_w bits).
package buffer_mac_pkg;

    localparam int unsigned DefaultDataW = 8;
    localparam int unsigned DefaultAddrW = 4;
    localparam int unsigned DefaultLanes = 4;
    localparam int unsigned DefaultAccW  = 24;
    localparam int unsigned DefaultLenW  = 8;

    // Working width of quantise(); wide enough for any sane ACC_W.
    localparam int unsigned QuantW = 64;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Returns the reduced value sign-extended to QuantW; the caller keeps the
    // low data_w bits.
    function automatic logic signed [QuantW-1:0] quantise(
        input logic signed [QuantW-1:0] acc,
        input logic        [4:0]        shift,
        input int unsigned              data_w
    );
        logic signed [QuantW-1:0] shifted;
        logic signed [QuantW-1:0] res;
`ifdef BUFFER_MAC_SAT_EN
        logic signed [QuantW-1:0] hi;
        logic signed [QuantW-1:0] lo;
`endif
        shifted = acc >>> shift;
`ifdef BUFFER_MAC_SAT_EN
        hi = (64'sd1 <<< (data_w - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 32'd1));
        if (shifted > hi) begin
            res = hi;
        end else if (shifted < lo) begin
            res = lo;
        end else begin
            res = shifted;
        end
`else
        // Wrap: keep the low data_w bits, re-sign-extended.
        res = (shifted <<< (QuantW - data_w)) >>> (QuantW - data_w);
`endif
        return res;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one multiply-accumulate channel of buffer_mac_array.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   clear          synchronous accumulator clear (job start)
//   in_valid       weight/act pair valid (pipeline stage 1 output)
//   weight, act    signed DATA_W operands
//   acc_nxt        next-state accumulator value (value after this edge)
// Stage 2 registers the full-width product, stage 3 adds it to the accumulator.
module mac_lane #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] act,
    output logic [ACC_W-1:0]  acc_nxt
);

    logic signed [2*DATA_W-1:0] w_ext;
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] prod_q;
    logic                       prod_valid_q;
    logic        [ACC_W-1:0]    acc_q;

    assign w_ext = (2*DATA_W)'($signed(weight));
    assign a_ext = (2*DATA_W)'($signed(act));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
        end else begin
            prod_valid_q <= in_valid;
            if (in_valid) begin
                prod_q <= w_ext * a_ext;
            end
        end
    end

    // Product is sign-extended to ACC_W; the add wraps modulo 2**ACC_W.
    always_comb begin
        acc_nxt = acc_q;
        if (clear) begin
            acc_nxt = '0;
        end else if (prod_valid_q) begin
            acc_nxt = acc_q + ACC_W'(prod_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_nxt;
        end
    end

endmodule

// File: rtl/buffer_mac_array.sv
// buffer_mac_array: weight buffer feeding LANES parallel MAC channels.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data          weight-row write (accepted in any state)
//   start, cfg_len, cfg_shift        job start with beat count and output shift
//   in_valid, in_ready, in_act,
//   in_addr                          activation beats; in_addr selects weight row
//   out_valid, out_ready, out_data   quantised per-lane result
//   busy                             FSM not idle
// Build option: BUFFER_MAC_SAT_EN selects saturating output reduction
// (handled in buffer_mac_pkg::quantise), default is wrap.
module buffer_mac_array
    import buffer_mac_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned LANES  = DefaultLanes,
    parameter int unsigned ACC_W  = DefaultAccW,
    parameter int unsigned LEN_W  = DefaultLenW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [LANES*DATA_W-1:0] wr_data,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [4:0]              cfg_shift,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_act,
    input  logic [ADDR_W-1:0]       in_addr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    busy
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned ROW_W = LANES*DATA_W;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q;
    logic [4:0]        shift_q;
    logic              drain_q;
    logic              clear;
    logic              accept;
    logic              load_out;

    logic [ROW_W-1:0]  mem_q [DEPTH];
    logic [ROW_W-1:0]  rd_row;
    logic [ROW_W-1:0]  w_q;
    logic [ROW_W-1:0]  a_q;
    logic              s1_valid_q;
    logic [ACC_W-1:0]  acc_nxt [LANES];
    logic [ROW_W-1:0]  out_d;
    logic [ROW_W-1:0]  out_q;

    assign accept   = in_valid && in_ready;
    // The last DRAIN cycle is also the final accumulate edge.
    assign load_out = (state_q == StDrain) && drain_q;
    assign out_data = out_q;

    // ---------------- control FSM ----------------
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        clear     = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    clear   = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                in_ready = 1'b1;
                if (in_valid && (cnt_q == LEN_W'(1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == StDrain) && !drain_q;
            if (clear) begin
                cnt_q   <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                shift_q <= cfg_shift;
            end else if (accept) begin
                cnt_q <= cnt_q - LEN_W'(1);
            end
        end
    end

    // ---------------- weight buffer ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Write-first bypass for a same-cycle write to the row being read.
    assign rd_row = (wr_en && (wr_addr == in_addr)) ? wr_data : mem_q[in_addr];

    // ---------------- stage 1: operand registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            w_q        <= '0;
            a_q        <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                w_q <= rd_row;
                a_q <= in_act;
            end
        end
    end

    // ---------------- stages 2/3: per-lane MAC ----------------
    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .in_valid (s1_valid_q),
            .weight   (w_q[i*DATA_W +: DATA_W]),
            .act      (a_q[i*DATA_W +: DATA_W]),
            .acc_nxt  (acc_nxt[i])
        );
    end

    // ---------------- output quantisation ----------------
    always_comb begin
        out_d = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            out_d[i*DATA_W +: DATA_W] =
                DATA_W'(quantise(QuantW'($signed(acc_nxt[i])), shift_q, DATA_W));
        end
    end

    // Result register holds its value after the handshake until the next job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else if (load_out) begin
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_buffer_mac_array.sv
module tb_buffer_mac_array;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int LANES  = 4;
    localparam int ACC_W  = 24;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 16;
    localparam int ROW_W  = LANES*DATA_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ROW_W-1:0] wr_data;
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic [4:0]       cfg_shift;
    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_act;
    logic [ADDR_W-1:0] in_addr;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_data;
    logic             busy;

    always #5 clk = ~clk;

    buffer_mac_array dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: weight buffer contents.
    logic [ROW_W-1:0] m_mem [DEPTH];

    // Beat description consumed by do_job.
    logic [ADDR_W-1:0] q_addr[$];
    logic [ROW_W-1:0]  q_act[$];
    bit                q_wen[$];
    logic [ADDR_W-1:0] q_waddr[$];
    logic [ROW_W-1:0]  q_wdata[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Accumulator wraps to ACC_W, then arithmetic shift, then reduction.
    function automatic logic [DATA_W-1:0] model_q(input longint acc, input int sh);
        longint m, a, s;
        logic [63:0] sb;
        m = longint'(1) << ACC_W;
        a = acc & (m - 1);
        if (a >= m / 2) a = a - m;
        s = a >>> sh;
`ifdef BUFFER_MAC_SAT_EN
        if (s > (2**(DATA_W-1)) - 1) s = (2**(DATA_W-1)) - 1;
        if (s < -(2**(DATA_W-1))) s = -(2**(DATA_W-1));
`endif
        sb = s;
        return sb[DATA_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int addr, input logic [ROW_W-1:0] data);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        tick();
        wr_en = 1'b0;
        m_mem[addr] = data;
    endtask

    task automatic clear_beats();
        q_addr.delete(); q_act.delete(); q_wen.delete(); q_waddr.delete(); q_wdata.delete();
    endtask

    task automatic push_beat(input int addr, input logic [ROW_W-1:0] act, input bit wen,
                             input int waddr, input logic [ROW_W-1:0] wdata);
        q_addr.push_back(ADDR_W'(addr));
        q_act.push_back(act);
        q_wen.push_back(wen);
        q_waddr.push_back(ADDR_W'(waddr));
        q_wdata.push_back(wdata);
    endtask

    task automatic fill_beats(input int n, input bit wr);
        clear_beats();
        for (int i = 0; i < n; i++) begin
            int a;
            a = $urandom_range(0, DEPTH-1);
            push_beat(a, ROW_W'($urandom), wr && ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 1) == 1) ? a : $urandom_range(0, DEPTH-1),
                      ROW_W'($urandom));
        end
    endtask

    // Runs one complete job and checks handshake timing and result.
    task automatic do_job(input int len_cfg, input int shift, input int gap_at,
                          input int gap_len, input int hold, input bit spur);
        longint acc [LANES];
        logic [ROW_W-1:0] row;
        logic [ROW_W-1:0] exp;
        int eff, n, cyc;
        for (int l = 0; l < LANES; l++) acc[l] = 0;
        eff = (len_cfg == 0) ? 1 : len_cfg;
        start     = 1'b1;
        cfg_len   = LEN_W'(len_cfg);
        cfg_shift = 5'(shift);
        tick();
        start = 1'b0;
        check_eq("busy_run", busy, 1);
        n = 0;
        cyc = 0;
        while (n < eff) begin
            check_eq("in_ready_run", in_ready, 1);
            check_eq("ov_run", out_valid, 0);
            if (spur) begin
                start     = 1'($urandom_range(0, 1));
                cfg_len   = LEN_W'($urandom);
                cfg_shift = 5'($urandom);
            end
            if (cyc >= gap_at && cyc < gap_at + gap_len) begin
                in_valid = 1'b0;
                wr_en    = 1'b0;
                in_act   = ROW_W'($urandom);
            end else begin
                in_valid = 1'b1;
                in_addr  = q_addr[n];
                in_act   = q_act[n];
                wr_en    = q_wen[n];
                wr_addr  = q_waddr[n];
                wr_data  = q_wdata[n];
                row = (q_wen[n] && q_waddr[n] == q_addr[n]) ? q_wdata[n] : m_mem[q_addr[n]];
                for (int l = 0; l < LANES; l++) begin
                    acc[l] += longint'($signed(row[l*DATA_W +: DATA_W])) *
                              longint'($signed(q_act[n][l*DATA_W +: DATA_W]));
                end
                if (q_wen[n]) m_mem[q_waddr[n]] = q_wdata[n];
                n++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        wr_en    = 1'b0;
        for (int l = 0; l < LANES; l++) exp[l*DATA_W +: DATA_W] = model_q(acc[l], shift);
        check_eq("ov_lat1", out_valid, 0);
        check_eq("in_ready_drain", in_ready, 0);
        tick();
        check_eq("ov_lat2", out_valid, 0);
        tick();
        check_eq("ov_lat3", out_valid, 1);
        check_eq("result", out_data, exp);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            if (spur) start = 1'($urandom_range(0, 1));
            tick();
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_data", out_data, exp);
            check_eq("hold_in_ready", in_ready, 0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("ov_drop", out_valid, 0);
        check_eq("busy_idle", busy, 0);
        check_eq("data_kept", out_data, exp);
    endtask

    initial begin
        logic [7:0] v;
        reset = 1'b0;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        start = 0; cfg_len = 0; cfg_shift = 0;
        in_valid = 0; in_act = 0; in_addr = 0; out_ready = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out_data", out_data, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Rows 1..5 hold 2..6, act=1 -> 20 per lane.
        clear_beats();
        for (int r = 1; r <= 5; r++) begin
            v = 8'(r + 1);
            write_row(r, {4{v}});
            push_beat(r, {4{8'd1}}, 0, 0, 0);
        end
        do_job(5, 0, 1000, 0, 0, 0);
        check_eq("dot20", out_data, 32'h14141414);

        // 127*127*4 = 64516: saturate or wrap, then shift 9 -> 126.
        write_row(8, {4{8'd127}});
        clear_beats();
        for (int i = 0; i < 4; i++) push_beat(8, {4{8'd127}}, 0, 0, 0);
        do_job(4, 0, 1000, 0, 0, 0);
`ifdef BUFFER_MAC_SAT_EN
        check_eq("big_shift0", out_data, 32'h7f7f7f7f);
`else
        check_eq("big_shift0", out_data, 32'h04040404);
`endif
        do_job(4, 9, 1000, 0, 0, 0);
        check_eq("big_shift9", out_data, 32'h7e7e7e7e);

        // Same-cycle write and read of row 15 returns the new data.
        write_row(15, {4{8'd5}});
        clear_beats();
        push_beat(15, {4{8'd1}}, 1, 15, {4{8'd19}});
        do_job(1, 0, 1000, 0, 0, 0);
        check_eq("write_first", out_data, 32'h13131313);

        // Backpressure in DONE with spurious start pulses.
        fill_beats(6, 1);
        do_job(6, 3, 1000, 0, 5, 1);

        // Gap of 3 cycles mid-job, then the same beats gap-free.
        fill_beats(7, 0);
        do_job(7, 2, 3, 3, 0, 0);
        do_job(7, 2, 1000, 0, 0, 0);

        // cfg_len = 0 behaves as one beat.
        fill_beats(1, 0);
        do_job(0, 1, 1000, 0, 0, 0);

        // Random jobs.
        for (int j = 0; j < 10; j++) begin
            int len;
            len = $urandom_range(1, 20);
            fill_beats(len, 1);
            do_job(len, $urandom_range(0, 15), $urandom_range(0, 6), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset during RUN aborts the job and clears the buffer.
        write_row(3, 32'h11223344);
        start = 1'b1; cfg_len = 8'd6; cfg_shift = 5'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_addr = 4'd3; in_act = 32'h01010101;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", in_ready, 0);
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_out_data", out_data, 0);
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("post_rst_no_out", out_valid, 0);
            check_eq("post_rst_idle", busy, 0);
        end
        clear_beats();
        push_beat(3, ROW_W'($urandom), 0, 0, 0);
        do_job(1, 0, 1000, 0, 0, 0);
        check_eq("post_rst_zero", out_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_mac_array.md
BUFFER_MAC_ARRAY -- requirements
Module: buffer_mac_array

Interface
REQ-001 Parameter DATA_W, 8, signed operand width for weights, activations and quantised outputs.
REQ-002 Parameter ADDR_W, 4, weight-buffer address width; DEPTH = 2**ADDR_W rows.
REQ-003 Parameter LANES, 4, parallel MAC channels; each buffer row holds LANES weights.
REQ-004 Parameter ACC_W, 24, accumulator width per lane.
REQ-005 Parameter LEN_W, 8, width of the beat-count field.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 wr_en / wr_addr / wr_data  in  1 / ADDR_W / LANES*DATA_W  weight-row write port; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-009 start / cfg_len / cfg_shift  in  1 / LEN_W / 5  starts a job of cfg_len beats with arithmetic output shift cfg_shift.
REQ-010 in_valid / in_ready  in / out  1 / 1  activation-beat handshake.
REQ-011 in_act / in_addr  in  LANES*DATA_W / ADDR_W  per-lane activations and the weight row they multiply.
REQ-012 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-013 out_data  out  LANES*DATA_W  quantised per-lane results.
REQ-014 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-015 FSM states are IDLE, RUN, DRAIN and DONE.
REQ-016 IDLE->RUN on start: latch cfg_len (0 treated as 1) into beat counter and cfg_shift; clear all accumulators.
REQ-017 start outside IDLE is ignored; latched configuration is unchanged.
REQ-018 in_ready = (state==RUN); a beat is accepted on in_valid && in_ready, which decrements the counter.
REQ-019 RUN->DRAIN on the cycle the last beat is accepted; DRAIN lasts exactly 2 cycles, then DONE.
REQ-020 Pipeline: cycle 1 registers weight row and act; cycle 2 registers product; cycle 3 adds product to accumulator.
REQ-021 out_valid asserts 3 cycles after the last beat is accepted; out_data stays stable while out_valid && !out_ready.
REQ-022 DONE->IDLE on out_ready; out_valid drops the next cycle, and out_data holds its last value.
REQ-023 Product is full 2*DATA_W signed, sign-extended to ACC_W; accumulator wraps modulo 2**ACC_W.
REQ-024 Output per lane = accumulator arithmetically right-shifted by the latched shift, then reduced to DATA_W per REQ-031/032.
REQ-025 Writes are accepted in every state.
REQ-026 A write and an accepted read to the same row in the same cycle return the new data (write-first).
REQ-027 Addresses wrap naturally within DEPTH; there is no out-of-range case.

Reset
REQ-028 While reset is low: state IDLE, all buffer rows and accumulators 0, pipeline valid bits 0.
REQ-029 While reset is low: in_ready=0, out_valid=0, busy=0, out_data=0.
REQ-030 Reset assertion mid-job aborts the job; no output is produced for it after release.

Configuration
REQ-031 With BUFFER_MAC_SAT_EN defined, the reduction saturates to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
REQ-032 Without BUFFER_MAC_SAT_EN, the reduction keeps the low DATA_W bits (wrap).

Structure
REQ-033 Package buffer_mac_pkg holds the default parameter constants, the FSM state enum and the quantise (shift plus saturate/wrap) function.
REQ-034 Sub-module mac_lane (one lane: product register, accumulator, clear) is instantiated LANES times via generate.

Verification
REQ-035 Write rows 1..5 with lane values 2..6; start len=5, shift=0; send rows 1..5 with act=1 on all lanes -> out_data=20 per lane, out_valid 3 cycles after the last beat.
REQ-036 Row 8 holds 127 on all lanes; len=4, act=127 -> sum 64516 -> SAT_EN: 127; no SAT_EN: 4 (low 8 bits); shift=9: 126 in both builds.
REQ-037 Write row 15=19 while reading row 15 in the same cycle, len=1, act=1 -> out_data=19 per lane.
REQ-038 Hold out_ready low 5 cycles in DONE -> out_data stable and in_ready=0; start pulses during the job are ignored.
REQ-039 Drop in_valid for 3 cycles mid-job -> the beat count is unaffected and the result equals the gap-free run.
REQ-040 Assert reset low during RUN -> all outputs 0 immediately; after release, a new len=1 job with weight 0 yields 0.
